// File: rtl/safe_lock_ctrl_if.sv
// Keypad-to-lock-controller interface for the 4-digit safe box.
// The master (keypad scanner side) drives key strobes and observes the
// lock status; the slave (lock controller) consumes keys and reports status.
interface safe_lock_ctrl_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        unlocked;
    logic        alarm;
    logic        err;
    logic [2:0]  digit_cnt;
    logic [15:0] entry;
    logic [2:0]  state;

    modport master (
        output key_valid,
        output key_code,
        input  unlocked,
        input  alarm,
        input  err,
        input  digit_cnt,
        input  entry,
        input  state
    );

    modport slave (
        input  key_valid,
        input  key_code,
        output unlocked,
        output alarm,
        output err,
        output digit_cnt,
        output entry,
        output state
    );
endinterface

// File: rtl/safe_lock_ctrl.sv
// Lock controller for the 4-digit safe box.
// Collects four keypad digits, compares them against the stored password,
// opens the safe, allows changing the password while open and relocks after
// a period without key activity.
// Optional feature macro SAFE_LOCKOUT_EN: when defined, MAX_FAIL consecutive
// wrong entries put the controller into LOCKOUT (alarm high) for
// LOCKOUT_CYCLES clocks; when undefined, wrong entries only pulse err and
// the alarm output is tied low.
module safe_lock_ctrl #(
    parameter logic [15:0] DEFAULT_PW       = 16'h1234,
    parameter int          MAX_FAIL         = 3,
    parameter int          LOCKOUT_CYCLES   = 1000,
    parameter int          AUTO_LOCK_CYCLES = 5000
) (
    input  logic              clk,
    input  logic              rst_n,
    safe_lock_ctrl_if.slave   bus
);

    localparam logic [2:0] ST_LOCKED  = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_OPEN    = 3'd2;
    localparam logic [2:0] ST_SET_PW  = 3'd3;
    localparam logic [2:0] ST_LOCKOUT = 3'd4;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CHANGE = 4'hC;
    localparam logic [3:0] KEY_LOCK   = 4'hD;

    localparam int                FAIL_W   = $clog2(MAX_FAIL + 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);

    // The relock happens on the idle edge that would bring the idle count
    // to AUTO_LOCK_CYCLES-1, so it fires while the timer still holds one less.
    localparam logic [31:0] IDLE_LAST    = 32'(AUTO_LOCK_CYCLES - 2);
    // Lockout lasts the full LOCKOUT_CYCLES: the timer walks 0..LOCKOUT_CYCLES-1.
    localparam logic [31:0] LOCKOUT_LAST = 32'(LOCKOUT_CYCLES - 1);

    logic [2:0]  state_q,   state_d;
    logic [15:0] pw_q,      pw_d;
    logic [15:0] entry_q,   entry_d;
    logic [2:0]  cnt_q,     cnt_d;
    logic [31:0] timer_q,   timer_d;
    logic        err_q,     err_d;

    logic        key_digit;
    logic        key_enter;
    logic        key_clear;
    logic        key_change;
    logic        key_lock;
    logic        entry_full;
    logic [15:0] entry_shifted;

`ifdef SAFE_LOCKOUT_EN
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
    logic [FAIL_W-1:0] fail_q, fail_d;
`else
    logic [FAIL_W-1:0] unused_fail_max;
    assign unused_fail_max = FAIL_MAX;
`endif

    // Classify the incoming key strobe and precompute the shifted entry
    always_comb begin
        key_digit     = bus.key_valid && (bus.key_code <= 4'd9);
        key_enter     = bus.key_valid && (bus.key_code == KEY_ENTER);
        key_clear     = bus.key_valid && (bus.key_code == KEY_CLEAR);
        key_change    = bus.key_valid && (bus.key_code == KEY_CHANGE);
        key_lock      = bus.key_valid && (bus.key_code == KEY_LOCK);
        entry_full    = (cnt_q == 3'd4);
        entry_shifted = {entry_q[11:0], bus.key_code};
    end

    // Next-state logic for the lock FSM, entry buffer, timer and password
    always_comb begin
        state_d = state_q;
        pw_d    = pw_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        err_d   = 1'b0;
`ifdef SAFE_LOCKOUT_EN
        fail_d  = fail_q;
`endif
        case (state_q)
            ST_LOCKED: begin
                timer_d = '0;
                if (key_digit) begin
                    if (!entry_full) begin
                        entry_d = entry_shifted;
                        cnt_d   = cnt_q + 3'd1;
                    end
                end else if (key_clear) begin
                    entry_d = '0;
                    cnt_d   = '0;
                end else if (key_enter) begin
                    if (entry_full) begin
                        state_d = ST_CHECK;
                    end else begin
                        err_d   = 1'b1;
                        entry_d = '0;
                        cnt_d   = '0;
                    end
                end
            end

            ST_CHECK: begin
                entry_d = '0;
                cnt_d   = '0;
                if (entry_q == pw_q) begin
                    state_d = ST_OPEN;
`ifdef SAFE_LOCKOUT_EN
                    fail_d  = '0;
`endif
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_LOCKED;
`ifdef SAFE_LOCKOUT_EN
                    if (fail_q >= FAIL_LAST) begin
                        fail_d  = FAIL_MAX;
                        state_d = ST_LOCKOUT;
                    end else begin
                        fail_d  = fail_q + 1'b1;
                    end
`endif
                end
            end

            ST_OPEN: begin
                if (bus.key_valid) begin
                    timer_d = '0;
                    if (key_lock) begin
                        state_d = ST_LOCKED;
                    end else if (key_change) begin
                        state_d = ST_SET_PW;
                    end
                end else if (timer_q == IDLE_LAST) begin
                    state_d = ST_LOCKED;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end

            ST_SET_PW: begin
                if (bus.key_valid) begin
                    timer_d = '0;
                    if (key_digit) begin
                        if (!entry_full) begin
                            entry_d = entry_shifted;
                            cnt_d   = cnt_q + 3'd1;
                        end
                    end else if (key_clear) begin
                        entry_d = '0;
                        cnt_d   = '0;
                    end else if (key_enter) begin
                        entry_d = '0;
                        cnt_d   = '0;
                        if (entry_full) begin
                            pw_d    = entry_q;
                            state_d = ST_OPEN;
                        end else begin
                            err_d   = 1'b1;
                        end
                    end else if (key_lock) begin
                        entry_d = '0;
                        cnt_d   = '0;
                        state_d = ST_LOCKED;
                    end
                end else if (timer_q == IDLE_LAST) begin
                    entry_d = '0;
                    cnt_d   = '0;
                    state_d = ST_LOCKED;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end

            ST_LOCKOUT: begin
                entry_d = '0;
                cnt_d   = '0;
                if (timer_q == LOCKOUT_LAST) begin
                    state_d = ST_LOCKED;
`ifdef SAFE_LOCKOUT_EN
                    fail_d  = '0;
`endif
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end

            default: begin
                state_d = ST_LOCKED;
                entry_d = '0;
                cnt_d   = '0;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    // State, password, entry buffer, timer and error pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOCKED;
            pw_q    <= DEFAULT_PW;
            entry_q <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pw_q    <= pw_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

`ifdef SAFE_LOCKOUT_EN
    // Consecutive failed-check counter, saturating at MAX_FAIL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_q <= '0;
        end else begin
            fail_q <= fail_d;
        end
    end

    assign bus.alarm = (state_q == ST_LOCKOUT);
`else
    assign bus.alarm = 1'b0;
`endif

    assign bus.state     = state_q;
    assign bus.unlocked  = (state_q == ST_OPEN) || (state_q == ST_SET_PW);
    assign bus.err       = err_q;
    assign bus.digit_cnt = cnt_q;
    assign bus.entry     = entry_q;

endmodule

// File: doc/safe_lock_ctrl.md
# safe_lock_ctrl

Lock controller for the 4-digit safe box. It consumes one-cycle key strobes from the keypad scanner and compares a 4-digit entry against a stored password. It drives the unlock and alarm outputs, supports password change while open, auto-relock on inactivity, and optional lockout after repeated failures.

## Interface
- DEFAULT_PW, 16'h1234: password loaded at reset; first-entered digit in [15:12].
- MAX_FAIL, 3: consecutive failed checks that trigger lockout (with SAFE_LOCKOUT_EN).
- LOCKOUT_CYCLES, 1000: length of lockout in clk cycles.
- AUTO_LOCK_CYCLES, 5000: key-idle cycles in OPEN before automatic relock.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe, key_code valid.
- key_code  in  4  0-9 digits; A = enter, B = clear, C = change password, D = lock; E/F ignored.
- unlocked  out  1  high in OPEN and SET_PW.
- alarm  out  1  high in LOCKOUT.
- err  out  1  registered one-cycle error pulse.
- digit_cnt  out  3  digits currently entered, 0-4.
- entry  out  16  entered digits for display, newest in [3:0].
- state  out  3  LOCKED=0, CHECK=1, OPEN=2, SET_PW=3, LOCKOUT=4.

## Operation
- Reset values:
  - state=LOCKED, pw=DEFAULT_PW.
  - entry=0, digit_cnt=0, fail_cnt=0, timer=0.
  - unlocked=0, alarm=0, err=0.
- Digit entry (LOCKED, SET_PW):
  - Digit key with digit_cnt<4: entry<={entry[11:0],key_code}, digit_cnt+1.
  - Digit key with digit_cnt==4: ignored.
  - B: entry=0, digit_cnt=0.
- LOCKED:
  - A with digit_cnt==4: go to CHECK.
  - A with digit_cnt<4: err pulse, entry and digit_cnt cleared, stay LOCKED.
  - C and D: ignored.
- CHECK (exactly one cycle, key_valid dropped). Entry and digit_cnt are cleared on exit.
  - entry==pw: go to OPEN, fail_cnt=0.
  - Mismatch: err pulse, fail_cnt+1, go to LOCKED. With SAFE_LOCKOUT_EN and fail_cnt+1==MAX_FAIL, go to LOCKOUT instead.
- OPEN:
  - D: go to LOCKED.
  - C: go to SET_PW, timer=0.
  - Digits, A, B: ignored.
  - Idle timer counts cycles without key_valid; any key_valid clears it. At AUTO_LOCK_CYCLES-1, go to LOCKED.
- SET_PW:
  - A with digit_cnt==4: pw<=entry, entry cleared, go to OPEN.
  - A with digit_cnt<4: err pulse, entry cleared, stay SET_PW.
  - D: abandon and go to LOCKED; pw unchanged.
  - The idle timer also runs here and relocks on expiry; pw unchanged.
- LOCKOUT:
  - All keys ignored, entry held at 0.
  - Timer counts to LOCKOUT_CYCLES-1, then go to LOCKED with fail_cnt=0.
- Widths: timer 32 bits, shared between idle and lockout and cleared on every state change; fail_cnt is $clog2(MAX_FAIL+1) bits and saturates.
- Unknown state encodings recover to LOCKED.

## Timing
- entry and digit_cnt update on the clk edge that samples key_valid.
- unlocked and alarm decode combinationally from the state register, so they change in the same cycle as state.
- Enter accepted at edge N:
  - state=CHECK after N.
  - Result state after N+1.
  - err on failure is high for the cycle after N+1.
- An err for a short entry is high for the cycle after the sampling edge.
- Idle timeout and key_valid on the same edge: the key wins; it is processed and the timer is cleared.
- Reset mid-operation clears everything, including a changed password, back to DEFAULT_PW.

## Configuration
- SAFE_LOCKOUT_EN defined:
  - fail_cnt tracked; the MAX_FAIL-th consecutive mismatch enters LOCKOUT for LOCKOUT_CYCLES.
  - Success clears fail_cnt.
- SAFE_LOCKOUT_EN undefined:
  - LOCKOUT is unreachable; mismatches only pulse err and return to LOCKED.
  - fail_cnt logic is removed; alarm is tied 0.

## Test plan
- Reset, keys 1,2,3,4,A → state CHECK then OPEN, unlocked=1, err=0, digit_cnt=0.
- Keys 1,2,3,A → err pulse for 1 cycle, state LOCKED, digit_cnt=0. Then 1,2,3,4,5 → entry=16'h1234, digit_cnt=4.
- Open, then C,9,8,7,6,A → pw=16'h9876, state OPEN. Then D,1,2,3,4,A → err, LOCKED. Then 9,8,7,6,A → OPEN.
- With SAFE_LOCKOUT_EN, three entries of 0,0,0,0,A → after the 3rd CHECK, alarm=1 for 1000 cycles with keys ignored, then LOCKED and 1,2,3,4,A opens. Without the macro → three err pulses, alarm=0.
- Open, no keys for 4999 cycles → state LOCKED. A key at cycle 4998 restarts the count.
- Assert rst_n=0 in SET_PW after entering 5,5 → LOCKED, pw=16'h1234, all outputs at reset values.
